// File: rtl/inputc_mvc_if.sv
// Signal bundle between the physical input link, the switch allocator and the crossbar
// for one multi-VC router input channel.
interface inputc_mvc_if #(
    parameter int NVC   = 4,
    parameter int DATAW = 64,
    parameter int VCW   = (NVC > 1) ? $clog2(NVC) : 1
);
    logic [DATAW-1:0] idata;
    logic             ivalid;
    logic [VCW-1:0]   ivch;
    logic [NVC-1:0]   ordy;
    logic [NVC-1:0]   oack;
    logic [NVC-1:0]   olck;
    logic [5*NVC-1:0] irdy;
    logic             req;
    logic [2:0]       port;
    logic             grt;
    logic [DATAW-1:0] odata;
    logic             ovalid;
    logic [VCW-1:0]   ovch;
    logic             err;

    modport master (
        output idata, ivalid, ivch, irdy, grt,
        input  ordy, oack, olck, req, port, odata, ovalid, ovch, err
    );

    modport slave (
        input  idata, ivalid, ivch, irdy, grt,
        output ordy, oack, olck, req, port, odata, ovalid, ovch, err
    );
endinterface

// File: rtl/inputc_mvc.sv
// Multi-VC router input channel: per-VC flit FIFO, XY route computation, packet FSM
// and a round-robin VC mux presenting one switch request per cycle.
module inputc_mvc #(
    parameter int NVC     = 4,
    parameter int DEPTH   = 4,
    parameter int DATAW   = 64,
    parameter int XYW     = 4,
    parameter int MY_XPOS = 0,
    parameter int MY_YPOS = 0
) (
    input  logic        clk,
    input  logic        rst_,
    inputc_mvc_if.slave bus
);
    localparam int VCW = (NVC > 1) ? $clog2(NVC) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int RW  = $clog2(5 * NVC);
    localparam logic [XYW-1:0] MY_X    = XYW'(MY_XPOS);
    localparam logic [XYW-1:0] MY_Y    = XYW'(MY_YPOS);
    localparam logic [AW:0]    PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ROUTE  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_E = 3'd1;
    localparam logic [2:0] P_S = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    logic [DATAW-1:0] mem   [NVC][DEPTH];
    logic [AW:0]      wptr  [NVC];
    logic [AW:0]      rptr  [NVC];
    logic [1:0]       state [NVC];
    logic [2:0]       vport [NVC];
    logic [VCW-1:0]   rr;

    logic [DATAW-1:0] front [NVC];
    logic [NVC-1:0]   full, empty, wr, ovf, drop, elig, pop;
    logic             found, grant;
    logic [VCW-1:0]   win;

    function automatic logic [2:0] xy_route(input logic [DATAW-1:0] f);
        logic [XYW-1:0] dx, dy;
        dx = f[2*XYW-1:XYW];
        dy = f[XYW-1:0];
        if (dx > MY_X)      return P_E;
        else if (dx < MY_X) return P_W;
        else if (dy > MY_Y) return P_S;
        else if (dy < MY_Y) return P_N;
        return P_L;
    endfunction

    // Flit type lives in the top two bits: [DATAW-1] marks a head, [DATAW-2] a tail.
    always_comb begin
        logic [AW:0]   cnt;
        logic [RW-1:0] ridx;
        cnt  = '0;
        ridx = '0;
        for (int unsigned v = 0; v < NVC; v++) begin
            cnt      = wptr[v] - rptr[v];
            full[v]  = (cnt == FULL_CNT);
            empty[v] = (cnt == '0);
            front[v] = mem[v][rptr[v][AW-1:0]];
            ovf[v]   = bus.ivalid && (bus.ivch == VCW'(v)) && full[v];
            wr[v]    = bus.ivalid && (bus.ivch == VCW'(v)) && !full[v];
            drop[v]  = (state[v] == S_IDLE) && !empty[v] && !front[v][DATAW-1];
            ridx     = RW'(vport[v]) * RW'(NVC) + RW'(v);
            elig[v]  = (state[v] == S_ACTIVE) && !empty[v] && bus.irdy[ridx];
            bus.olck[v] = (state[v] == S_ACTIVE);
        end
    end

    always_comb begin
        logic [VCW-1:0] cand;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NVC; i++) begin
            cand = VCW'((32'(rr) + i) % NVC);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        grant = found && bus.grt;
        for (int unsigned v = 0; v < NVC; v++) begin
            pop[v] = drop[v] || (grant && (win == VCW'(v)));
        end
    end

    assign bus.req  = found;
    assign bus.port = found ? vport[win] : P_N;
    assign bus.ordy = ~full;
    assign bus.oack = pop;

    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < NVC; v++) begin
            if (wr[v]) mem[v][wptr[v][AW-1:0]] <= bus.idata;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int unsigned v = 0; v < NVC; v++) begin
                wptr[v]  <= '0;
                rptr[v]  <= '0;
                state[v] <= S_IDLE;
                vport[v] <= P_N;
            end
            rr         <= '0;
            bus.ovalid <= 1'b0;
            bus.odata  <= '0;
            bus.ovch   <= '0;
            bus.err    <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < NVC; v++) begin
                if (wr[v])  wptr[v] <= wptr[v] + PTR_ONE;
                if (pop[v]) rptr[v] <= rptr[v] + PTR_ONE;
                case (state[v])
                    S_IDLE:   if (!empty[v] && front[v][DATAW-1]) state[v] <= S_ROUTE;
                    S_ROUTE: begin
                        vport[v] <= xy_route(front[v]);
                        state[v] <= S_ACTIVE;
                    end
                    S_ACTIVE: if (grant && (win == VCW'(v)) && front[v][DATAW-2]) state[v] <= S_IDLE;
                    default:  state[v] <= S_IDLE;
                endcase
            end
            if (grant) rr <= (win == VCW'(NVC - 1)) ? '0 : win + VCW'(1);
            bus.ovalid <= grant;
            bus.odata  <= grant ? front[win] : '0;
            bus.ovch   <= grant ? win : '0;
            bus.err    <= bus.err | (|ovf) | (|drop);
        end
    end
endmodule
